key_filter: RTL and testbench

- Debounces one raw, active-low mechanical key and produces a clean level, a one-cycle press pulse, and a select bit.
- Sits directly upstream of mux_2: sel_out drives mux_2.sel, so a board button switches the mux between inputs a and b without glitches.
- Single clock domain; key_in is asynchronous to it.

---
 rtl/key_filter_pkg.sv | 16 +
 rtl/key_filter_sync_2ff.sv | 24 ++
 rtl/key_filter.sv | 110 +++++++++++
 tb/tb_key_filter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/key_filter_pkg.sv
// Shared definitions for the key_filter debouncer: FSM state encoding and
// the default filter length for a 50 MHz system clock.
package key_filter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_FILT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_FILT = 2'd3
    } state_t;

    // 1_000_000 cycles of stability = 20 ms at 50 MHz
    localparam int          CNT_W_DEFAULT = 20;
    localparam logic [19:0] CNT_MAX_50MHZ = 20'd999_999;

endpackage

// File: rtl/key_filter_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit board input.
// RST_VAL sets the idle level both flops take during reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/key_filter.sv
// Debouncer for one active-low key: clean level, one-cycle press flag and a mux select.
// Define KEY_TOGGLE_EN to make sel_out toggle on each press instead of following the level.
module key_filter
    import key_filter_pkg::*;
#(
    parameter int             CNT_W   = CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_MAX_50MHZ)
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_in,
    output logic       key_level,
    output logic       key_flag,
    output logic       sel_out,
    output logic [1:0] state_dbg
);

    logic             key_sync;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_nxt, flag_nxt, sel_nxt;

    // Reset value 1 keeps a key held through reset looking released until re-sampled
    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .d     (key_in),
        .q     (key_sync)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            key_level <= 1'b0;
            key_flag  <= 1'b0;
            sel_out   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            key_level <= level_nxt;
            key_flag  <= flag_nxt;
            sel_out   <= sel_nxt;
        end
    end

    // A bounce back to the stable level drops to the stable state with cnt cleared
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (!key_sync) begin
                    state_nxt = ST_PRESS_FILT;
                    cnt_nxt   = '0;
                end
            end
            ST_PRESS_FILT: begin
                if (key_sync) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = ST_PRESSED;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (key_sync) begin
                    state_nxt = ST_RELEASE_FILT;
                    cnt_nxt   = '0;
                end
            end
            ST_RELEASE_FILT: begin
                if (!key_sync) begin
                    state_nxt = ST_PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        level_nxt = key_level;
        flag_nxt  = 1'b0;
        if (state == ST_PRESS_FILT && state_nxt == ST_PRESSED) begin
            level_nxt = 1'b1;
            flag_nxt  = 1'b1;
        end
        if (state == ST_RELEASE_FILT && state_nxt == ST_IDLE) begin
            level_nxt = 1'b0;
        end
`ifdef KEY_TOGGLE_EN
        sel_nxt = sel_out ^ key_flag;
`else
        sel_nxt = level_nxt;
`endif
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter (CNT_MAX=9): directed bounce/glitch/reset phases plus
// random key activity, checked against a run-length debounce model.
module tb_key_filter;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 9;
    localparam int RUN     = CNT_MAX + 2;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       key_in    = 1'b1;
    logic       key_level;
    logic       key_flag;
    logic       sel_out;
    logic [1:0] state_dbg;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: raw key delayed by the synchroniser, level flips after RUN agreeing samples
    logic m_d1 = 1'b1, m_d2 = 1'b1, m_lvl = 1'b0, m_sel = 1'b0, m_flag_prev = 1'b0;
    int   run_len = 0;
    logic [31:0] exp_q[$];

    always #10 sys_clk = ~sys_clk;

    key_filter #(.CNT_W(CNT_W), .CNT_MAX(4'(CNT_MAX))) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (key_in),
        .key_level (key_level),
        .key_flag  (key_flag),
        .sel_out   (sel_out),
        .state_dbg (state_dbg)
    );

    always @(posedge sys_clk) begin
        logic samp;
        cyc++;
        if (!sys_rst_n) begin
            m_d1 = 1'b1; m_d2 = 1'b1; m_lvl = 1'b0; m_sel = 1'b0;
            m_flag_prev = 1'b0; run_len = 0;
        end else begin
            samp = m_d2;
            m_d2 = m_d1;
            m_d1 = key_in;
`ifdef KEY_TOGGLE_EN
            if (m_flag_prev) m_sel = ~m_sel;
`endif
            m_flag_prev = 1'b0;
            if ((!samp) != m_lvl) run_len++;
            else                  run_len = 0;
            if (run_len == RUN) begin
                m_lvl   = ~m_lvl;
                run_len = 0;
                if (m_lvl) begin
                    exp_q.push_back(32'(cyc));
                    m_flag_prev = 1'b1;
                end
            end
`ifndef KEY_TOGGLE_EN
            m_sel = m_lvl;
`endif
        end
    end

    task automatic check_val(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: mid-cycle sampling; flag pulses pop the expected-edge queue
    always @(posedge sys_clk) begin
        int exp_state;
        logic [31:0] t;
        #5;
        check_val("key_level", int'(key_level), int'(m_lvl));
        check_val("sel_out", int'(sel_out), int'(m_sel));
        if (!sys_rst_n) exp_state = 0;
        else if (!m_lvl) exp_state = (run_len == 0) ? 0 : 1;
        else             exp_state = (run_len == 0) ? 2 : 3;
        check_val("state", int'(state_dbg), exp_state);
        if (key_flag) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_flag", 1, 0);
            end else begin
                t = exp_q.pop_front();
                check_val("flag_cycle", cyc, int'(t));
            end
        end else if (exp_q.size() > 0 && int'(exp_q[0]) <= cyc) begin
            t = exp_q.pop_front();
            check_val("missed_flag_cycle", 0, int'(t));
        end
    end

    task automatic hold(input logic v, input int n);
        key_in = v;
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        hold(1'b1, 30);
        // clean press and release
        hold(1'b0, 20);
        hold(1'b1, 20);
        // bouncing press
        hold(1'b0, 3); hold(1'b1, 3); hold(1'b0, 3); hold(1'b1, 3);
        hold(1'b0, 20);
        // short release glitch, then real release
        hold(1'b1, 5);
        hold(1'b0, 10);
        hold(1'b1, 20);
        // reset in the middle of the press filter with the key held
        hold(1'b0, 8);
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        hold(1'b0, 20);
        hold(1'b1, 20);
        // three full press/release cycles
        for (int i = 0; i < 3; i++) begin
            hold(1'b0, 20);
            hold(1'b1, 20);
        end
        // random bounces and holds
        for (int i = 0; i < 150; i++) begin
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 25));
        end
        hold(1'b1, 20);
        check_val("pending_flags", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
